envelope_channel_scheduler: RTL and testbench

//   Time-multiplexes one shared Ornstein-Uhlenbeck envelope update datapath across
//   NUM_CH oscillator channels. Holds per-channel envelope (Q14) and 16-bit LFSR state.
//   On each decimated clk_en tick, sweeps channels 0..NUM_CH-1 through the datapath over
//   a req/ack handshake, and writes the results back. Sits between the 4 kHz tick source
//   and the oscillator bank. Oscillators read their per-channel MU scale from this block.

---
 rtl/envelope_channel_scheduler.sv | 160 ++++++++++++++++
 tb/tb_envelope_channel_scheduler.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_channel_scheduler.sv
// Per-channel Ornstein-Uhlenbeck envelope scheduler: holds envelope and LFSR
// state for NUM_CH channels and sweeps them through one shared update datapath
// over a req/ack handshake once every 2^DECIMATE_BITS clk_en ticks.
module envelope_channel_scheduler #(
  parameter int          WIDTH         = 18,
  parameter int          FRAC          = 14,
  parameter int          NUM_CH        = 8,
  parameter int          CH_BITS       = 3,
  parameter int          DECIMATE_BITS = 4,
  parameter logic [15:0] SEED_BASE     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [WIDTH-1:0]   tau_inv_cfg,
  input  logic               cfg_load,
  output logic               dp_req,
  output logic [CH_BITS-1:0] dp_ch,
  output logic [WIDTH-1:0]   dp_envelope,
  output logic [15:0]        dp_lfsr,
  output logic [WIDTH-1:0]   dp_tau_inv,
  input  logic               dp_ack,
  input  logic [WIDTH-1:0]   dp_envelope_next,
  input  logic [15:0]        dp_lfsr_next,
  input  logic [CH_BITS-1:0] rd_ch,
  output logic [WIDTH-1:0]   rd_envelope,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic               overrun
);

  localparam logic [WIDTH-1:0]   ENV_ONE = WIDTH'(1 << FRAC);
  localparam logic [WIDTH-1:0]   ENV_MIN = WIDTH'(1 << (FRAC - 1));
  localparam logic [WIDTH-1:0]   ENV_MAX = WIDTH'((1 << FRAC) + (1 << (FRAC - 1)));
  localparam logic [WIDTH-1:0]   TAU_ONE = WIDTH'(1);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t                   state, state_next;
  logic [WIDTH-1:0]         env_mem  [NUM_CH];
  logic [15:0]              lfsr_mem [NUM_CH];
  logic [WIDTH-1:0]         tau_shadow, tau_active, cap_env;
  logic [15:0]              cap_lfsr;
  logic [DECIMATE_BITS-1:0] dec_cnt;
  logic [CH_BITS-1:0]       ch;
  logic                     tick, req, capture;

  // Distinct per-channel seed; an all-zero LFSR would lock up, so avoid it.
  function automatic logic [15:0] reset_seed(input int unsigned c);
    logic [15:0] s;
    s = SEED_BASE ^ 16'(c * 32'h9E37);
    return (s == '0) ? 16'hACE1 : s;
  endfunction

  // Keep the envelope inside [0.5, 1.5] whatever the datapath returns.
  function automatic logic [WIDTH-1:0] clamp_env(input logic [WIDTH-1:0] v);
    if ($signed(v) < $signed(ENV_MIN)) return ENV_MIN;
    if ($signed(v) > $signed(ENV_MAX)) return ENV_MAX;
    return v;
  endfunction

  assign tick    = clk_en && (dec_cnt == '0);
  assign req     = (state == ISSUE) || (state == WAIT);
  assign capture = req && dp_ack;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: one ISSUE/WAIT handshake then one WRITE per channel.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        if (tick) state_next = ISSUE;
      ISSUE, WAIT: state_next = dp_ack ? WRITE : WAIT;
      WRITE:       state_next = (ch == LAST_CH) ? IDLE : ISSUE;
      default:     state_next = IDLE;
    endcase
  end

  // Datapath request outputs; held at zero whenever no request is outstanding.
  always_comb begin
    dp_req      = req;
    dp_ch       = '0;
    dp_envelope = '0;
    dp_lfsr     = '0;
    dp_tau_inv  = '0;
    if (req) begin
      dp_ch       = ch;
      dp_envelope = env_mem[ch];
      dp_lfsr     = lfsr_mem[ch];
      dp_tau_inv  = tau_active;
    end
  end

  // Sweep control: decimation, tau shadowing, channel index, status flags, result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt    <= '0;
      tau_shadow <= TAU_ONE;
      tau_active <= TAU_ONE;
      ch         <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      overrun    <= 1'b0;
      cap_env    <= '0;
      cap_lfsr   <= '0;
    end else begin
      sweep_done <= 1'b0;
      if (clk_en) dec_cnt <= dec_cnt + 1'b1;
      if (cfg_load)
        tau_shadow <= (tau_inv_cfg[WIDTH-1] || tau_inv_cfg == '0) ? TAU_ONE : tau_inv_cfg;
      if (tick && sweep_busy) overrun <= 1'b1;
      if (capture) begin
        cap_env  <= clamp_env(dp_envelope_next);
        cap_lfsr <= (dp_lfsr_next == '0) ? SEED_BASE : dp_lfsr_next;
      end
      case (state)
        IDLE: if (tick) begin
          tau_active <= tau_shadow;
          ch         <= '0;
          sweep_busy <= 1'b1;
        end
        WRITE: begin
          if (ch == LAST_CH) begin
            sweep_busy <= 1'b0;
            sweep_done <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel state storage; committed only in WRITE, so a reset mid-sweep leaves no partial update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        env_mem[CH_BITS'(c)]  <= ENV_ONE;
        lfsr_mem[CH_BITS'(c)] <= reset_seed(c);
      end
    end else if (state == WRITE) begin
      env_mem[ch]  <= cap_env;
      lfsr_mem[ch] <= cap_lfsr;
    end
  end

  // Registered read port; a same-cycle write is not forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rd_envelope <= '0;
    else if (rd_ch <= LAST_CH) rd_envelope <= env_mem[rd_ch];
    else                     rd_envelope <= '0;
  end

endmodule

// File: tb/tb_envelope_channel_scheduler.sv
// Directed self-checking bench for envelope_channel_scheduler with a
// behavioural datapath responder (configurable ack latency and result).
module tb_envelope_channel_scheduler;
  localparam int WIDTH   = 18;
  localparam int NUM_CH  = 8;
  localparam int CH_BITS = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clk_en = 1'b0;
  logic [WIDTH-1:0]   tau_inv_cfg = '0;
  logic               cfg_load = 1'b0;
  logic               dp_req;
  logic [CH_BITS-1:0] dp_ch;
  logic [WIDTH-1:0]   dp_envelope;
  logic [15:0]        dp_lfsr;
  logic [WIDTH-1:0]   dp_tau_inv;
  logic               dp_ack = 1'b0;
  logic [WIDTH-1:0]   dp_envelope_next = '0;
  logic [15:0]        dp_lfsr_next = '0;
  logic [CH_BITS-1:0] rd_ch = '0;
  logic [WIDTH-1:0]   rd_envelope;
  logic               sweep_busy, sweep_done, overrun;

  int tests = 0;
  int fails = 0;

  // responder controls: mode 0 = echo env+resp_add, mode 1 = ch0->30000, ch1->100, ch2 lfsr->0
  int resp_mode = 0;
  int resp_add  = 0;
  int wait_n    = 0;
  int wcnt      = 0;
  logic [15:0]      seen_lfsr [NUM_CH];
  logic [WIDTH-1:0] seen_env  [NUM_CH];
  logic [WIDTH-1:0] seen_tau  [NUM_CH];

  envelope_channel_scheduler #(
    .WIDTH(18), .FRAC(14), .NUM_CH(8), .CH_BITS(3), .DECIMATE_BITS(4), .SEED_BASE(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tau_inv_cfg(tau_inv_cfg), .cfg_load(cfg_load),
    .dp_req(dp_req), .dp_ch(dp_ch), .dp_envelope(dp_envelope), .dp_lfsr(dp_lfsr),
    .dp_tau_inv(dp_tau_inv), .dp_ack(dp_ack), .dp_envelope_next(dp_envelope_next),
    .dp_lfsr_next(dp_lfsr_next), .rd_ch(rd_ch), .rd_envelope(rd_envelope),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Datapath model: answers on the (wait_n+1)-th request cycle, records what it was shown.
  always @(negedge clk) begin
    if (dp_req) begin
      seen_lfsr[dp_ch] = dp_lfsr;
      seen_env[dp_ch]  = dp_envelope;
      seen_tau[dp_ch]  = dp_tau_inv;
      if (wcnt >= wait_n) begin
        dp_ack           = 1'b1;
        wcnt             = 0;
        dp_envelope_next = dp_envelope + 18'(resp_add);
        dp_lfsr_next     = dp_lfsr;
        if (resp_mode == 1) begin
          case (dp_ch)
            3'd0: dp_envelope_next = 18'd30000;
            3'd1: dp_envelope_next = 18'd100;
            3'd2: dp_lfsr_next     = 16'h0000;
            default: ;
          endcase
        end
      end else begin
        dp_ack = 1'b0;
        wcnt++;
      end
    end else begin
      dp_ack = 1'b0;
      wcnt   = 0;
    end
  end

  task automatic apply_reset();
    rst = 1'b1; clk_en = 1'b0; cfg_load = 1'b0; tau_inv_cfg = '0; rd_ch = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_env(input int c, output logic [WIDTH-1:0] v);
    rd_ch = CH_BITS'(c);
    @(negedge clk);
    v = rd_envelope;
  endtask

  task automatic check_all_env(input string name, input logic [WIDTH-1:0] exp);
    logic [WIDTH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) begin
      read_env(c, v);
      tests++;
      if (v !== exp) begin
        fails++;
        $display("FAIL %s ch%0d: rd_envelope=%0d required %0d", name, c, v, exp);
      end
    end
  endtask

  // Pulse clk_en (with a gap) until a sweep begins.
  task automatic start_sweep();
    int n = 0;
    while (!sweep_busy && n < 40) begin
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      n++;
      if (!sweep_busy) @(negedge clk);
    end
    tests++;
    if (!sweep_busy) begin
      fails++;
      $display("FAIL start_sweep: sweep_busy=%0b required 1 after %0d pulses", sweep_busy, n);
    end
  endtask

  task automatic finish_sweep();
    int n = 0;
    while (!sweep_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!sweep_done) begin
      fails++;
      $display("FAIL finish_sweep: sweep_done=%0b required 1 within 1000 cycles", sweep_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({dp_req, dp_ch, dp_envelope, dp_lfsr, dp_tau_inv, rd_envelope, sweep_busy, sweep_done, overrun} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: req=%0b ch=%0d env=%0d lfsr=%h tau=%0d rd=%0d busy=%0b done=%0b ovr=%0b required all 0",
               dp_req, dp_ch, dp_envelope, dp_lfsr, dp_tau_inv, rd_envelope, sweep_busy, sweep_done, overrun);
    end
    rst = 1'b0;
    @(negedge clk);
    check_all_env("reset_env", 18'd16384);
    tests++;
    if (dp_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_req: dp_req=%0b required 0", dp_req);
    end
  endtask

  task automatic test_decimation();
    int st[3];
    int nst = 0;
    int dones = 0;
    int t0 = 0;
    int nneg = 0;
    int done_first = -1;
    logic prev_busy = 1'b0;
    apply_reset();
    resp_mode = 0; resp_add = 100; wait_n = 0;
    for (int k = 1; k <= 33; k++) begin
      for (int j = 0; j < 10; j++) begin
        if (k == 5 && j >= 2) begin
          tests++;
          if (rd_envelope !== 18'd16484) begin
            fails++;
            $display("FAIL sweep1_env ch%0d: rd_envelope=%0d required 16484", j - 2, rd_envelope);
          end
        end
        if (k == 5 && j >= 1 && j <= 8) rd_ch = CH_BITS'(j - 1);
        clk_en = (j == 0);
        if (k == 1 && j == 0) t0 = nneg;
        @(negedge clk);
        nneg++;
        if (sweep_busy && !prev_busy) begin
          if (nst < 3) st[nst] = k;
          nst++;
        end
        prev_busy = sweep_busy;
        if (sweep_done) begin
          dones++;
          if (done_first < 0) done_first = nneg - t0;
          tests++;
          if (sweep_busy !== 1'b0) begin
            fails++;
            $display("FAIL done_busy: sweep_busy=%0b required 0 with sweep_done", sweep_busy);
          end
        end
      end
    end
    clk_en = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (sweep_done) dones++;
    end
    tests++;
    if (nst !== 3 || st[0] !== 1 || st[1] !== 17 || st[2] !== 33) begin
      fails++;
      $display("FAIL sweep_starts: count=%0d at pulses %0d,%0d,%0d required 3 at 1,17,33", nst, st[0], st[1], st[2]);
    end
    tests++;
    if (dones !== 3) begin
      fails++;
      $display("FAIL done_pulses: %0d required 3", dones);
    end
    // tick is sampled one edge after it is driven, so done shows 2*NUM_CH+1 negedges later
    tests++;
    if (done_first !== 2 * NUM_CH + 1) begin
      fails++;
      $display("FAIL sweep_latency: %0d required %0d", done_first, 2 * NUM_CH + 1);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL no_overrun: overrun=%0b required 0", overrun);
    end
    check_all_env("three_sweeps", 18'd16684);
  endtask

  task automatic test_wait_states();
    int exp_ch = 0;
    int rlen = 0;
    apply_reset();
    resp_mode = 0; resp_add = 7; wait_n = 3;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    for (int n = 0; n < 100 && !sweep_done; n++) begin
      if (dp_req) begin
        tests++;
        if (dp_ch !== CH_BITS'(exp_ch) || dp_envelope !== 18'd16384) begin
          fails++;
          $display("FAIL wait_dp: ch=%0d env=%0d required ch=%0d env=16384", dp_ch, dp_envelope, exp_ch);
        end
        rlen++;
      end else if (rlen > 0) begin
        tests++;
        if (rlen !== 4) begin
          fails++;
          $display("FAIL wait_req_len ch%0d: %0d cycles required 4", exp_ch, rlen);
        end
        exp_ch++;
        rlen = 0;
      end
      @(negedge clk);
    end
    tests++;
    if (exp_ch !== NUM_CH || sweep_done !== 1'b1) begin
      fails++;
      $display("FAIL wait_visits: %0d channels done=%0b required %0d done=1", exp_ch, sweep_done, NUM_CH);
    end
    @(negedge clk);
    wait_n = 0;
    check_all_env("wait_commit", 18'd16391);
  endtask

  task automatic test_clamp();
    logic [WIDTH-1:0] v;
    apply_reset();
    resp_mode = 1; resp_add = 0; wait_n = 0;
    start_sweep();
    finish_sweep();
    tests++;
    if (seen_lfsr[0] !== 16'hACE1 || seen_lfsr[1] !== 16'h32D6) begin
      fails++;
      $display("FAIL reset_seeds: lfsr0=%h lfsr1=%h required ace1 32d6", seen_lfsr[0], seen_lfsr[1]);
    end
    read_env(0, v);
    tests++;
    if (v !== 18'd24576) begin fails++; $display("FAIL clamp_high: %0d required 24576", v); end
    read_env(1, v);
    tests++;
    if (v !== 18'd8192) begin fails++; $display("FAIL clamp_low: %0d required 8192", v); end
    read_env(2, v);
    tests++;
    if (v !== 18'd16384) begin fails++; $display("FAIL clamp_pass: %0d required 16384", v); end
    resp_mode = 0;
    for (int c = 0; c < NUM_CH; c++) seen_lfsr[c] = '0;
    start_sweep();
    finish_sweep();
    tests++;
    if (seen_lfsr[2] !== 16'hACE1) begin
      fails++;
      $display("FAIL lfsr_zero: stored %h required ace1", seen_lfsr[2]);
    end
    tests++;
    if (seen_lfsr[3] !== 16'h7644 || seen_env[0] !== 18'd24576) begin
      fails++;
      $display("FAIL state_kept: lfsr3=%h env0=%0d required 7644 24576", seen_lfsr[3], seen_env[0]);
    end
  endtask

  task automatic test_cfg_load();
    apply_reset();
    resp_mode = 0; resp_add = 0; wait_n = 0;
    start_sweep();
    repeat (3) @(negedge clk);
    tau_inv_cfg = 18'd2;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    finish_sweep();
    tests++;
    if (seen_tau[0] !== 18'd1 || seen_tau[7] !== 18'd1) begin
      fails++;
      $display("FAIL tau_midsweep: ch0=%0d ch7=%0d required 1 1", seen_tau[0], seen_tau[7]);
    end
    start_sweep();
    finish_sweep();
    tests++;
    if (seen_tau[0] !== 18'd2 || seen_tau[7] !== 18'd2) begin
      fails++;
      $display("FAIL tau_next: ch0=%0d ch7=%0d required 2 2", seen_tau[0], seen_tau[7]);
    end
    tau_inv_cfg = 18'h3FFFB;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    start_sweep();
    finish_sweep();
    tests++;
    if (seen_tau[0] !== 18'd1) begin
      fails++;
      $display("FAIL tau_negative: %0d required 1", seen_tau[0]);
    end
  endtask

  task automatic test_overrun_reset();
    apply_reset();
    resp_mode = 0; resp_add = 100; wait_n = 0;
    start_sweep();
    finish_sweep();
    tests++;
    if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear: %0b required 0", overrun); end
    wait_n = 1000;
    start_sweep();
    for (int i = 0; i < 16; i++) begin
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (overrun !== 1'b1 || sweep_busy !== 1'b1 || dp_req !== 1'b1 || dp_ch !== 3'd0) begin
      fails++;
      $display("FAIL overrun_set: ovr=%0b busy=%0b req=%0b ch=%0d required 1 1 1 0", overrun, sweep_busy, dp_req, dp_ch);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (overrun !== 1'b0 || sweep_busy !== 1'b0 || dp_req !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: ovr=%0b busy=%0b req=%0b required 0 0 0", overrun, sweep_busy, dp_req);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_n = 0;
    @(negedge clk);
    check_all_env("reset_restore", 18'd16384);
  endtask

  initial begin
    test_reset();
    test_decimation();
    test_wait_states();
    test_clamp();
    test_cfg_load();
    test_overrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
